// File: rtl/qr_rot_sched.sv
// qr_rot_sched: angle FIFO plus pass sequencer feeding the shared 4-micro-rotation CORDIC datapath.
// Optional macro SCALE_COMP_EN adds a one-cycle CORDIC gain-compensation state ahead of OUT.
module qr_rot_sched #(
  parameter int Q_LEN      = 12,
  parameter int ITER_NUM   = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ang_valid,
  output logic                    ang_ready,
  input  logic [2*ITER_NUM-1:0]   ang_d,
  input  logic                    ang_neg,
  input  logic                    ang_nop,
  input  logic                    vec_valid,
  output logic                    vec_ready,
  input  logic signed [Q_LEN-1:0] vec_x,
  input  logic signed [Q_LEN-1:0] vec_y,
  input  logic                    vec_last,
  output logic signed [Q_LEN-1:0] q_xi,
  output logic signed [Q_LEN-1:0] q_yi,
  output logic [3:0]              q_iter,
  output logic [1:0]              q_d1,
  output logic [1:0]              q_d2,
  output logic [1:0]              q_d3,
  output logic [1:0]              q_d4,
  output logic                    q_neg,
  output logic                    q_nop,
  input  logic signed [Q_LEN-1:0] q_xo,
  input  logic signed [Q_LEN-1:0] q_yo,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [Q_LEN-1:0] res_x,
  output logic signed [Q_LEN-1:0] res_y,
  output logic                    res_last,
  output logic                    busy
);
  localparam int P     = ITER_NUM / 4;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [1:0]       LAST_PASS = 2'(P - 1);
  localparam logic [PTR_W-1:0] PTR_MAX   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ROT, SCALE, OUT} state_t;
  state_t state, state_nxt;

  logic [2*ITER_NUM-1:0]   d_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   neg_mem, nop_mem;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    full, empty, push, pop, vec_hs, res_hs;
  logic [2*ITER_NUM-1:0]   head_d;
  logic                    head_neg, head_nop;
  logic [31:0]             d_pad;
  logic [7:0]              pass_d;
  logic signed [Q_LEN-1:0] x_p0, y_p0;
  logic                    last_p0;
  logic [1:0]              pass_p0;

`ifdef SCALE_COMP_EN
  // Shift-add approximation of 1/K (~0.6074); truncating, never widens.
  function automatic logic signed [Q_LEN-1:0] scale_k(input logic signed [Q_LEN-1:0] v);
    return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
  endfunction
`endif

  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);
  assign ang_ready = !full;
  assign push      = ang_valid && !full;
  assign vec_hs    = (state == IDLE) && !empty && vec_valid;
  assign res_hs    = (state == OUT) && res_ready;
  assign pop       = res_hs && last_p0;
  assign busy      = (state != IDLE) || !empty;

  assign head_d   = d_mem[rd_ptr];
  assign head_neg = neg_mem[rd_ptr];
  assign head_nop = nop_mem[rd_ptr];

  // Angle storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      d_mem[wr_ptr]   <= ang_d;
      neg_mem[wr_ptr] <= ang_neg;
      nop_mem[wr_ptr] <= ang_nop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Pad to four passes so the pass slice is always in range.
  always_comb begin
    d_pad = '1;
    d_pad[2*ITER_NUM-1:0] = head_d;
  end
  assign pass_d = d_pad[{pass_p0, 3'b000} +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    vec_ready = 1'b0;
    res_valid = 1'b0;
    q_iter    = 4'd0;
    q_d1      = 2'd2;
    q_d2      = 2'd2;
    q_d3      = 2'd2;
    q_d4      = 2'd2;
    q_neg     = 1'b0;
    q_nop     = 1'b1;
    case (state)
      IDLE: begin
        vec_ready = !empty;
        if (vec_hs) state_nxt = ROT;
      end
      ROT: begin
        q_iter = {pass_p0, 2'b00};
        q_d1   = pass_d[1:0];
        q_d2   = pass_d[3:2];
        q_d3   = pass_d[5:4];
        q_d4   = pass_d[7:6];
        q_neg  = head_neg && (pass_p0 == 2'd0);
        q_nop  = head_nop;
`ifdef SCALE_COMP_EN
        if (pass_p0 == LAST_PASS) state_nxt = SCALE;
`else
        if (pass_p0 == LAST_PASS) state_nxt = OUT;
`endif
      end
      SCALE: state_nxt = OUT;
      OUT: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand registers: loaded on accept, updated by each pass, held through OUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_p0    <= '0;
      y_p0    <= '0;
      last_p0 <= 1'b0;
      pass_p0 <= 2'd0;
    end else begin
      case (state)
        IDLE: if (vec_hs) begin
          x_p0    <= vec_x;
          y_p0    <= vec_y;
          last_p0 <= vec_last;
          pass_p0 <= 2'd0;
        end
        ROT: begin
          x_p0    <= q_xo;
          y_p0    <= q_yo;
          pass_p0 <= pass_p0 + 2'd1;
        end
`ifdef SCALE_COMP_EN
        SCALE: if (!head_nop) begin
          x_p0 <= scale_k(x_p0);
          y_p0 <= scale_k(y_p0);
        end
`endif
        default: ;
      endcase
    end
  end

  assign q_xi     = x_p0;
  assign q_yi     = y_p0;
  assign res_x    = x_p0;
  assign res_y    = y_p0;
  assign res_last = last_p0;
endmodule
